// File: rtl/mux_bist_ctrl.sv
// Self-test sequencer for a 2:1 mux: walks all eight {s,i1,i0} vectors and
// checks y against s ? i1 : i0 after a programmable settle time.
module mux_bist_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             y,
   output logic             i0,
   output logic             i1,
   output logic             s,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       fail_vec
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [2:0] idx;
   logic [7:0] settle_cnt;
   logic       exp_y;
   logic       mismatch;

   // Error count sticks at its maximum instead of wrapping.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   assign exp_y    = idx[2] ? idx[1] : idx[0];
   assign mismatch = (y != exp_y);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         {s, i1, i0} <= 3'b000;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_vec   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  err_count   <= '0;
                  fail_vec    <= '0;
                  idx         <= '0;
                  {s, i1, i0} <= 3'b000;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  settle_cnt  <= '0;
                  state       <= SETTLE;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 8'd1;
               if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
            end
            SAMPLE: begin
               if (mismatch) begin
                  fail_vec[idx] <= 1'b1;
                  err_count     <= sat_inc(err_count);
               end
               if (idx != 3'd7) begin
                  idx         <= idx + 3'd1;
                  {s, i1, i0} <= idx + 3'd1;
                  settle_cnt  <= '0;
                  state       <= SETTLE;
               end else begin
                  // Pass must reflect the final vector's result too.
                  {s, i1, i0} <= 3'b000;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  pass        <= (err_count == '0) && !mismatch;
                  state       <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
